// File: rtl/mpu_load.sv
// Matrix load unit: streams elements from a valid/ready memory source into the
// matrix register file in row-major order, one registered write per accepted beat.
module mpu_load #(
    parameter int FPBITS          = 31,
    parameter int MBITS           = 3,
    parameter int NBITS           = 3,
    parameter int MATRIX_REG_BITS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_req_in,
    input  logic [MATRIX_REG_BITS:0]   load_addr_in,
    input  logic [MBITS:0]             load_m_size_in,
    input  logic [NBITS:0]             load_n_size_in,
    output logic                       load_busy_out,
    output logic                       load_done_out,
    output logic                       load_err_out,
    input  logic                       mem_valid_in,
    input  logic [FPBITS:0]            mem_element_in,
    output logic                       mem_ready_out,
    output logic                       reg_load_en_out,
    output logic [FPBITS:0]            reg_load_element_out,
    output logic [MBITS:0]             reg_i_load_loc_out,
    output logic [NBITS:0]             reg_j_load_loc_out,
    output logic [MATRIX_REG_BITS:0]   reg_load_addr_out,
    output logic [MBITS:0]             reg_m_load_size_out,
    output logic [NBITS:0]             reg_n_load_size_out
);

    typedef enum logic [1:0] {
        LOAD_IDLE   = 2'd0,
        LOAD_MATRIX = 2'd1,
        LOAD_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [MATRIX_REG_BITS:0] addr_q, addr_d;
    logic [MBITS:0]           m_q, m_d, row_q, row_d, i_q, i_d;
    logic [NBITS:0]           n_q, n_d, col_q, col_d, j_q, j_d;
    logic [FPBITS:0]          elem_q, elem_d;
    logic                     en_q, en_d, err_q, err_d;

    logic accept, last_row, last_col, size_zero, start;

    assign size_zero = (load_m_size_in == '0) || (load_n_size_in == '0);
    assign start     = (state_q == LOAD_IDLE) && load_req_in && !size_zero;
    assign accept    = mem_valid_in && mem_ready_out;
    assign last_row  = (row_q == (m_q - {{MBITS{1'b0}}, 1'b1}));
    assign last_col  = (col_q == (n_q - {{NBITS{1'b0}}, 1'b1}));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_IDLE:   if (start) state_d = LOAD_MATRIX;
            LOAD_MATRIX: if (accept && last_row && last_col) state_d = LOAD_DONE;
            LOAD_DONE:   state_d = LOAD_IDLE;
            default:     state_d = LOAD_IDLE;
        endcase
    end

    // Ready is a pure state decode; done lines up with the final registered write.
    always_comb begin
        load_busy_out = (state_q == LOAD_MATRIX) || (state_q == LOAD_DONE);
        mem_ready_out = (state_q == LOAD_MATRIX);
        load_done_out = (state_q == LOAD_DONE);
    end

    always_comb begin
        addr_d = addr_q;
        m_d    = m_q;
        n_d    = n_q;
        row_d  = row_q;
        col_d  = col_q;
        elem_d = elem_q;
        i_d    = i_q;
        j_d    = j_q;
        en_d   = accept;
        err_d  = (state_q == LOAD_IDLE) && load_req_in && size_zero;

        if (start) begin
            addr_d = load_addr_in;
            m_d    = load_m_size_in;
            n_d    = load_n_size_in;
            row_d  = '0;
            col_d  = '0;
        end

        if (accept) begin
            elem_d = mem_element_in;
            i_d    = row_q;
            j_d    = col_q;
            // Pointers hold on the final element so they never wrap.
            if (last_col) begin
                if (!last_row) begin
                    row_d = row_q + {{MBITS{1'b0}}, 1'b1};
                    col_d = '0;
                end
            end else begin
                col_d = col_q + {{NBITS{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            m_q    <= '0;
            n_q    <= '0;
            row_q  <= '0;
            col_q  <= '0;
            elem_q <= '0;
            i_q    <= '0;
            j_q    <= '0;
            en_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            m_q    <= m_d;
            n_q    <= n_d;
            row_q  <= row_d;
            col_q  <= col_d;
            elem_q <= elem_d;
            i_q    <= i_d;
            j_q    <= j_d;
            en_q   <= en_d;
            err_q  <= err_d;
        end
    end

    assign load_err_out         = err_q;
    assign reg_load_en_out      = en_q;
    assign reg_load_element_out = elem_q;
    assign reg_i_load_loc_out   = i_q;
    assign reg_j_load_loc_out   = j_q;
    assign reg_load_addr_out    = addr_q;
    assign reg_m_load_size_out  = m_q;
    assign reg_n_load_size_out  = n_q;

endmodule

// File: tb/tb_mpu_load.sv
// Bench for mpu_load: a per-cycle behavioural model (element counter with
// div/mod addressing) is compared against every output on each falling edge.
module tb_mpu_load;

    logic        clk;
    logic        rst;
    logic        load_req_in;
    logic [3:0]  load_addr_in;
    logic [3:0]  load_m_size_in;
    logic [3:0]  load_n_size_in;
    logic        load_busy_out;
    logic        load_done_out;
    logic        load_err_out;
    logic        mem_valid_in;
    logic [31:0] mem_element_in;
    logic        mem_ready_out;
    logic        reg_load_en_out;
    logic [31:0] reg_load_element_out;
    logic [3:0]  reg_i_load_loc_out;
    logic [3:0]  reg_j_load_loc_out;
    logic [3:0]  reg_load_addr_out;
    logic [3:0]  reg_m_load_size_out;
    logic [3:0]  reg_n_load_size_out;

    mpu_load dut (
        .clk                  (clk),
        .rst                  (rst),
        .load_req_in          (load_req_in),
        .load_addr_in         (load_addr_in),
        .load_m_size_in       (load_m_size_in),
        .load_n_size_in       (load_n_size_in),
        .load_busy_out        (load_busy_out),
        .load_done_out        (load_done_out),
        .load_err_out         (load_err_out),
        .mem_valid_in         (mem_valid_in),
        .mem_element_in       (mem_element_in),
        .mem_ready_out        (mem_ready_out),
        .reg_load_en_out      (reg_load_en_out),
        .reg_load_element_out (reg_load_element_out),
        .reg_i_load_loc_out   (reg_i_load_loc_out),
        .reg_j_load_loc_out   (reg_j_load_loc_out),
        .reg_load_addr_out    (reg_load_addr_out),
        .reg_m_load_size_out  (reg_m_load_size_out),
        .reg_n_load_size_out  (reg_n_load_size_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: phase 0 idle, 1 loading, 2 done cycle
    int          mdl_phase = 0;
    int          mdl_cnt   = 0;
    int          exp_m     = 0;
    int          exp_n     = 0;
    logic [3:0]  exp_addr  = '0;
    logic        exp_en    = 1'b0;
    logic        exp_err   = 1'b0;
    logic [31:0] exp_elem  = '0;
    logic [3:0]  exp_i     = '0;
    logic [3:0]  exp_j     = '0;

    // Observation log filled by the compare process
    int n_wr = 0, n_done = 0, n_busy = 0, n_err = 0, n_done_wr = 0;
    int          wi[$];
    int          wj[$];
    logic [31:0] we[$];

    logic [31:0] tbl [6] = '{32'h3f800000, 32'h40000000, 32'h40400000,
                             32'h40800000, 32'h40a00000, 32'h40c00000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        bit acc;
        @(posedge clk);
        if (rst) begin
            mdl_phase = 0; mdl_cnt = 0; exp_m = 0; exp_n = 0; exp_addr = '0;
            exp_en = 1'b0; exp_err = 1'b0; exp_elem = '0; exp_i = '0; exp_j = '0;
        end else begin
            acc     = (mdl_phase == 1) && mem_valid_in;
            exp_en  = acc;
            exp_err = 1'b0;
            if (acc) begin
                exp_elem = mem_element_in;
                exp_i    = 4'(mdl_cnt / exp_n);
                exp_j    = 4'(mdl_cnt % exp_n);
                mdl_cnt++;
            end
            case (mdl_phase)
                0: if (load_req_in) begin
                       if (load_m_size_in == 0 || load_n_size_in == 0) begin
                           exp_err = 1'b1;
                       end else begin
                           exp_addr  = load_addr_in;
                           exp_m     = int'(load_m_size_in);
                           exp_n     = int'(load_n_size_in);
                           mdl_cnt   = 0;
                           mdl_phase = 1;
                       end
                   end
                1: if (acc && mdl_cnt == exp_m * exp_n) mdl_phase = 2;
                default: mdl_phase = 0;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        chk("busy",  32'(load_busy_out),        32'(mdl_phase != 0));
        chk("ready", 32'(mem_ready_out),        32'(mdl_phase == 1));
        chk("done",  32'(load_done_out),        32'(mdl_phase == 2));
        chk("err",   32'(load_err_out),         32'(exp_err));
        chk("wr_en", 32'(reg_load_en_out),      32'(exp_en));
        chk("elem",  reg_load_element_out,      exp_elem);
        chk("loc_i", 32'(reg_i_load_loc_out),   32'(exp_i));
        chk("loc_j", 32'(reg_j_load_loc_out),   32'(exp_j));
        chk("addr",  32'(reg_load_addr_out),    32'(exp_addr));
        chk("m_sz",  32'(reg_m_load_size_out),  32'(exp_m));
        chk("n_sz",  32'(reg_n_load_size_out),  32'(exp_n));
        if (reg_load_en_out === 1'b1) begin
            n_wr++;
            wi.push_back(int'(reg_i_load_loc_out));
            wj.push_back(int'(reg_j_load_loc_out));
            we.push_back(reg_load_element_out);
            $display("write (%0d,%0d) data=%h addr=%0d", reg_i_load_loc_out,
                     reg_j_load_loc_out, reg_load_element_out, reg_load_addr_out);
        end
        if (load_done_out === 1'b1) n_done++;
        if (load_done_out === 1'b1 && reg_load_en_out === 1'b1) n_done_wr++;
        if (load_busy_out === 1'b1) n_busy++;
        if (load_err_out === 1'b1) n_err++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        n_wr = 0; n_done = 0; n_busy = 0; n_err = 0; n_done_wr = 0;
        wi.delete(); wj.delete(); we.delete();
    endtask

    // mode: 0 valid held, 1 valid toggling, 2 random valid
    task automatic do_load(input int m, input int n, input int a, input int mode,
                           input bit interfere, input bit use_tbl);
        int idx = 0;
        int cyc = 0;
        bit acc;
        load_req_in = 1'b1; load_m_size_in = 4'(m); load_n_size_in = 4'(n);
        load_addr_in = 4'(a); mem_valid_in = 1'b0; mem_element_in = $urandom;
        tick();
        load_req_in = 1'b0;
        while (mdl_phase != 0 && cyc < 5000) begin
            case (mode)
                0:       mem_valid_in = 1'b1;
                1:       mem_valid_in = (cyc % 2 == 0);
                default: mem_valid_in = 1'($urandom_range(0, 1));
            endcase
            mem_element_in = use_tbl ? tbl[idx % 6] : $urandom;
            if (interfere) begin
                load_req_in = 1'b1; load_addr_in = 4'd5;
                load_m_size_in = 4'd1; load_n_size_in = 4'd1;
            end
            acc = (mdl_phase == 1) && mem_valid_in;
            tick();
            if (acc) idx++;
            cyc++;
        end
        load_req_in = 1'b0; mem_valid_in = 1'b0;
        if (cyc >= 5000) begin
            checks++; errors++;
            $display("FAIL load_timeout: got busy after %0d cycles expected idle", cyc);
        end
    endtask

    initial begin
        rst = 1'b1; load_req_in = 1'b0; load_addr_in = '0; load_m_size_in = '0;
        load_n_size_in = '0; mem_valid_in = 1'b0; mem_element_in = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy",  32'(load_busy_out), 32'd0);
        chk("reset_ready", 32'(mem_ready_out), 32'd0);
        chk("reset_en",    32'(reg_load_en_out), 32'd0);
        tick();

        // 2x3 with valid held high and data 1.0..6.0
        clear_stats();
        do_load(2, 3, 3, 0, 1'b0, 1'b1);
        tick();
        chk("s1_writes", 32'(n_wr), 32'd6);
        chk("s1_done",   32'(n_done), 32'd1);
        chk("s1_done_with_write", 32'(n_done_wr), 32'd1);
        chk("s1_busy_cycles", 32'(n_busy), 32'd7);
        if (n_wr == 6) begin
            int ei[6] = '{0, 0, 0, 1, 1, 1};
            int ej[6] = '{0, 1, 2, 0, 1, 2};
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("s1_i%0d", k), 32'(wi[k]), 32'(ei[k]));
                chk($sformatf("s1_j%0d", k), 32'(wj[k]), 32'(ej[k]));
                chk($sformatf("s1_d%0d", k), we[k], tbl[k]);
            end
        end

        // 2x2 with valid toggling
        clear_stats();
        do_load(2, 2, 7, 1, 1'b0, 1'b0);
        tick();
        chk("s2_writes", 32'(n_wr), 32'd4);
        chk("s2_done_with_write", 32'(n_done_wr), 32'd1);
        if (n_wr == 4) begin
            chk("s2_pos2", 32'(wi[2] * 16 + wj[2]), 32'h10);
            chk("s2_pos3", 32'(wi[3] * 16 + wj[3]), 32'h11);
        end

        // zero-size request
        clear_stats();
        do_load(0, 3, 2, 0, 1'b0, 1'b0);
        tick(); tick();
        chk("s3_err",    32'(n_err), 32'd1);
        chk("s3_busy",   32'(n_busy), 32'd0);
        chk("s3_writes", 32'(n_wr), 32'd0);

        // 3x3 with requests hammered during the load
        clear_stats();
        do_load(3, 3, 9, 2, 1'b1, 1'b0);
        tick();
        chk("s4_writes", 32'(n_wr), 32'd9);
        chk("s4_addr",   32'(reg_load_addr_out), 32'd9);
        chk("s4_m",      32'(reg_m_load_size_out), 32'd3);

        // reset after three accepts of a 3x3 load
        clear_stats();
        load_req_in = 1'b1; load_m_size_in = 4'd3; load_n_size_in = 4'd3; load_addr_in = 4'd6;
        tick();
        load_req_in = 1'b0; mem_valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_element_in = $urandom;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_valid_in = 1'b0;
        chk("s5_rst_busy", 32'(load_busy_out), 32'd0);
        chk("s5_rst_en",   32'(reg_load_en_out), 32'd0);
        chk("s5_rst_addr", 32'(reg_load_addr_out), 32'd0);
        tick();
        chk("s5_writes", 32'(n_wr), 32'd3);
        chk("s5_done",   32'(n_done), 32'd0);
        clear_stats();
        do_load(1, 1, 4, 0, 1'b0, 1'b0);
        tick();
        chk("s5b_writes", 32'(n_wr), 32'd1);
        chk("s5b_done",   32'(n_done), 32'd1);

        // 1x1 then 1x2 issued on the very next idle cycle
        clear_stats();
        do_load(1, 1, 1, 0, 1'b0, 1'b0);
        do_load(1, 2, 2, 0, 1'b0, 1'b0);
        tick();
        chk("s6_writes", 32'(n_wr), 32'd3);
        chk("s6_done",   32'(n_done), 32'd2);
        if (n_wr == 3) chk("s6_pos2", 32'(wi[2] * 16 + wj[2]), 32'h01);

        // largest matrix
        clear_stats();
        do_load(15, 15, 15, 0, 1'b0, 1'b0);
        tick();
        chk("max_writes", 32'(n_wr), 32'd225);
        if (n_wr == 225) chk("max_last_pos", 32'(wi[224] * 16 + wj[224]), 32'hee);

        // randomized loads, including zero-size requests
        for (int r = 0; r < 25; r++) begin
            do_load($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 15),
                    2, 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mpu_load.md
Name: mpu_load

Overview:
- Moves a matrix from an external memory source into the matrix register file, one floating-point element per accepted beat, in row-major order.
- The memory side uses a valid/ready handshake. The register-file side gets a registered write strobe with (i,j) location, target matrix address and latched dimensions.
- Sits beside the store unit in the MPU datapath and is started by the MPU controller.

Parameters:
- FPBITS, 31, MSB index of a float element (element width FPBITS+1)
- MBITS, 3, MSB index of row count/pointer
- NBITS, 3, MSB index of column count/pointer
- MATRIX_REG_BITS, 3, MSB index of matrix register address

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- load_req_in  in  1  start request from controller; sampled only in LOAD_IDLE
- load_addr_in  in  MATRIX_REG_BITS+1  target matrix register address
- load_m_size_in  in  MBITS+1  rows M to load
- load_n_size_in  in  NBITS+1  columns N to load
- load_busy_out  out  1  high in LOAD_MATRIX and LOAD_DONE
- load_done_out  out  1  one-cycle pulse, coincident with the final register write
- load_err_out  out  1  one-cycle pulse when a request has M==0 or N==0
- mem_valid_in  in  1  memory presents a valid element
- mem_element_in  in  FPBITS+1  element data
- mem_ready_out  out  1  block accepts an element this cycle
- reg_load_en_out  out  1  register-file write strobe
- reg_load_element_out  out  FPBITS+1  element to write
- reg_i_load_loc_out  out  MBITS+1  row index of the write
- reg_j_load_loc_out  out  NBITS+1  column index of the write
- reg_load_addr_out  out  MATRIX_REG_BITS+1  latched target register
- reg_m_load_size_out  out  MBITS+1  latched M
- reg_n_load_size_out  out  NBITS+1  latched N

Behaviour:
- States: LOAD_IDLE, LOAD_MATRIX, LOAD_DONE. On reset the state is LOAD_IDLE and every output plus internal pointer and latch is 0.
- LOAD_IDLE:
  - load_req_in=1 with M!=0 and N!=0: latch addr, M and N; clear row_ptr and col_ptr; go to LOAD_MATRIX.
  - load_req_in=1 with M==0 or N==0: load_err_out=1 the next cycle for one cycle; stay in LOAD_IDLE.
- mem_ready_out is 1 in every LOAD_MATRIX cycle and 0 in all other states. It is a pure state decode, not dependent on mem_valid_in.
- Accept = mem_valid_in & mem_ready_out. mem_valid_in without ready is ignored; no write occurs.
- On accept in cycle T, at T+1 (one-stage registered write path):
  - reg_load_en_out=1
  - reg_load_element_out = accepted data
  - i/j = pointer values at T
- Without an accept in T, reg_load_en_out=0 at T+1. The element and i/j outputs hold their last values.
- Pointer advance on accept, row-major:
  - col_ptr == N-1 and row_ptr == M-1: last element; next state LOAD_DONE; pointers hold.
  - col_ptr == N-1 otherwise: row_ptr+1, col_ptr=0.
  - Otherwise: col_ptr+1.
- LOAD_DONE lasts exactly one cycle:
  - load_done_out=1 in the same cycle as the final reg_load_en_out.
  - mem_ready_out=0.
  - Next state LOAD_IDLE.
- Throughput: one element per cycle with continuous valid, so an MxN load takes M*N cycles in LOAD_MATRIX. The final write occurs in the single LOAD_DONE cycle.
- Request inputs (load_req_in, load_addr_in, sizes) are ignored while busy. Latched sizes and address are stable for the whole load.
- reg_load_addr_out and the reg_m/n size outputs reflect the latched values and hold them after completion until the next accepted request.
- A new request is accepted in the first LOAD_IDLE cycle after LOAD_DONE, giving back-to-back loads with one idle cycle.
- Reset mid-load: state goes to LOAD_IDLE and all outputs go to 0 on the next edge. The partial load is abandoned, and no write or done pulse is produced for any element accepted in the reset cycle.
- M=1, N=1: a single accept moves directly to LOAD_DONE.
- Max size is 2^(MBITS+1)-1 rows by 2^(NBITS+1)-1 columns. Pointer comparisons are width-exact with no wrap.

Test Plan:
- 2x3 load, valid held high, data 1.0..6.0 -> six writes on consecutive cycles at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2) with matching data; done on the 6th write; busy high for 7 cycles.
- 2x2 load with valid toggling 1,0,1,0,... -> writes only on the cycle after each accept, in order (0,0),(0,1),(1,0),(1,1); no extra writes; done with the 4th.
- Request with M=0, N=3 -> load_err_out pulses once; busy, ready and writes stay 0.
- During a 3x3 load, load_req_in=1 with addr=5 and M=1 -> ignored; reg_load_addr_out keeps the original addr; exactly 9 writes.
- rst asserted after 3 accepts of a 3x3 load -> next cycle all outputs 0; no done; a subsequent 1x1 request loads at (0,0) and pulses done.
- 1x1 load, then an immediate second 1x2 request on the idle cycle -> writes (0,0), then (0,0),(0,1); two done pulses.
